// File: rtl/pipeline_exec_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline execution controller:
//   - state_e        : controller state encoding
//   - CMD_*          : debug-unit command codes (other codes behave as NOP)
//   - cause_e        : halt-cause codes reported on halt_cause_o
//   - HALT_OPCODE_DEFAULT : opcode field value that marks program end
//   - bp_idx_width() : width of a breakpoint slot index (at least one bit)
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_RUN   = 3'd1;
  localparam logic [2:0] CMD_STEP  = 3'd2;
  localparam logic [2:0] CMD_PAUSE = 3'd3;
  localparam logic [2:0] CMD_CLEAR = 3'd4;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_PAUSE   = 2'd1,
    CAUSE_BREAK   = 2'd2,
    CAUSE_HALT_OP = 2'd3
  } cause_e;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

  function automatic int bp_idx_width(input int n_bp);
    return (n_bp > 1) ? $clog2(n_bp) : 1;
  endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_exec_ctrl_if
// Command handshake and breakpoint-write bus between debug_unit (master) and
// pipeline_exec_ctrl (slave).
//   cmd_valid_i / cmd_i / cmd_ready_o : command channel, accepted on valid&&ready
//   bp_wr_i / bp_idx_i / bp_addr_i / bp_en_i : breakpoint slot write port
// Parameters: NB_PC (PC width), NB_BP_IDX (slot index width).
// -----------------------------------------------------------------------------
interface pipeline_exec_ctrl_if #(
  parameter int NB_PC     = 7,
  parameter int NB_BP_IDX = 1
);
  logic                 cmd_valid_i;
  logic [2:0]           cmd_i;
  logic                 cmd_ready_o;
  logic                 bp_wr_i;
  logic [NB_BP_IDX-1:0] bp_idx_i;
  logic [NB_PC-1:0]     bp_addr_i;
  logic                 bp_en_i;

  modport master (
    output cmd_valid_i, cmd_i, bp_wr_i, bp_idx_i, bp_addr_i, bp_en_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i, cmd_i, bp_wr_i, bp_idx_i, bp_addr_i, bp_en_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/pipeline_exec_ctrl_bp_compare.sv
// -----------------------------------------------------------------------------
// bp_compare
// N_BP breakpoint slots (address + enable) with a write port and a parallel
// comparator against the current fetch PC. Only built when
// PIPE_CTRL_BREAKPOINT_EN is defined (instantiated from pipeline_exec_ctrl).
// Ports:
//   clock, reset     : clock, async active-high reset (slots cleared/disabled)
//   wr_i, idx_i      : write strobe and slot index (out-of-range idx ignored)
//   addr_i, en_i     : address and enable stored into the slot
//   pc_i             : fetch PC to compare
//   match_o[N_BP]    : per-slot hit (slot enabled and address equal)
// -----------------------------------------------------------------------------
module bp_compare #(
  parameter int NB_PC  = 7,
  parameter int N_BP   = 2,
  parameter int NB_IDX = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_i,
  input  logic [NB_IDX-1:0] idx_i,
  input  logic [NB_PC-1:0]  addr_i,
  input  logic              en_i,
  input  logic [NB_PC-1:0]  pc_i,
  output logic [N_BP-1:0]   match_o
);

  logic [NB_PC-1:0] r_addr [N_BP];
  logic [N_BP-1:0]  r_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BP; i++) begin
        r_addr[i] <= '0;
        r_en[i]   <= 1'b0;
      end
    end else if (wr_i) begin
      for (int i = 0; i < N_BP; i++) begin
        if (idx_i == NB_IDX'(i)) begin
          r_addr[i] <= addr_i;
          r_en[i]   <= en_i;
        end
      end
    end
  end

  always_comb begin
    match_o = '0;
    for (int i = 0; i < N_BP; i++) begin
      match_o[i] = r_en[i] && (r_addr[i] == pc_i);
    end
  end

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_exec_ctrl
// Command-driven run/step/halt engine producing the global pipeline stage
// enable. Detects the HALT opcode and drains the pipeline for N_STAGES-1
// cycles, optionally stops on PC breakpoints, counts enabled cycles
// (saturating) and reports why execution last stopped.
// Optional feature macro: PIPE_CTRL_BREAKPOINT_EN (breakpoint slots,
// comparators and the resume skip flag; without it bp_* and pc_fetch_i are
// ignored and BREAK never occurs).
// Ports:
//   clock, reset       : system clock, async active-high reset
//   bus (slave)        : command handshake + breakpoint write port
//   pc_fetch_i         : current fetch PC
//   instr_fetch_i      : instruction at pc_fetch_i (opcode in top 6 bits)
//   en_pipeline_o      : registered global stage enable
//   halted_o           : controller is in DONE
//   halt_cause_o       : 0 NONE, 1 PAUSE, 2 BREAK, 3 HALT_OP
//   cycle_count_o      : enabled cycles since last CLEAR (saturating)
//   done_o             : one-cycle pulse on entering DONE
// -----------------------------------------------------------------------------
module pipeline_exec_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int         NB_PC       = 7,
  parameter int         NB_DATA     = 32,
  parameter int         N_STAGES    = 5,
  parameter int         NB_CYCLES   = 32,
  parameter int         N_BP        = 2,
  parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  pipeline_exec_ctrl_if.slave  bus,
  input  logic [NB_PC-1:0]     pc_fetch_i,
  input  logic [NB_DATA-1:0]   instr_fetch_i,
  output logic                 en_pipeline_o,
  output logic                 halted_o,
  output logic [1:0]           halt_cause_o,
  output logic [NB_CYCLES-1:0] cycle_count_o,
  output logic                 done_o
);

  localparam int DRAIN_LEN = (N_STAGES > 1) ? N_STAGES - 1 : 1;
  localparam int NB_DRAIN  = $clog2(DRAIN_LEN + 1);

  state_e               r_state, w_next;
  cause_e               r_cause, w_cause_nxt;
  logic [NB_DRAIN-1:0]  r_drain_cnt;
  logic [NB_CYCLES-1:0] r_count;
  logic                 r_en, r_done, r_halted;
  logic                 w_ready, w_accept, w_halt_op, w_bp_hit;
  logic                 w_clear, w_skip_set, w_en_nxt;
  logic                 w_unused_instr;

  assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_DONE);
  assign w_accept  = bus.cmd_valid_i && w_ready;
  assign w_halt_op = (instr_fetch_i[NB_DATA-1 -: 6] == HALT_OPCODE);
  assign w_unused_instr = ^instr_fetch_i[NB_DATA-7:0];

`ifdef PIPE_CTRL_BREAKPOINT_EN
  localparam int NB_BP_IDX = bp_idx_width(N_BP);

  logic [N_BP-1:0] w_bp_match;
  logic            r_skip;

  bp_compare #(
    .NB_PC  (NB_PC),
    .N_BP   (N_BP),
    .NB_IDX (NB_BP_IDX)
  ) u_bp_compare (
    .clock   (clock),
    .reset   (reset),
    .wr_i    (bus.bp_wr_i),
    .idx_i   (bus.bp_idx_i),
    .addr_i  (bus.bp_addr_i),
    .en_i    (bus.bp_en_i),
    .pc_i    (pc_fetch_i),
    .match_o (w_bp_match)
  );

  // Set when stopping on a breakpoint; dropped after the next enabled cycle,
  // so a resumed RUN does not re-trigger on the PC it stopped at.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           r_skip <= 1'b0;
    else if (w_skip_set) r_skip <= 1'b1;
    else if (r_en)       r_skip <= 1'b0;
  end

  assign w_bp_hit = (|w_bp_match) && !r_skip;
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{pc_fetch_i, bus.bp_wr_i, bus.bp_idx_i, bus.bp_addr_i, bus.bp_en_i};
  assign w_bp_hit    = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_cause_nxt = r_cause;
    w_clear     = 1'b0;
    w_skip_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_i)
            CMD_RUN:   w_next = ST_RUN;
            CMD_STEP:  w_next = ST_STEP;
            CMD_CLEAR: w_clear = 1'b1;
            default:   ;
          endcase
        end
      end
      ST_RUN: begin
        // HALT opcode beats PAUSE beats BREAK.
        if (w_halt_op) begin
          w_next = ST_DRAIN;
        end else if (w_accept && (bus.cmd_i == CMD_PAUSE)) begin
          w_next      = ST_IDLE;
          w_cause_nxt = CAUSE_PAUSE;
        end else if (w_bp_hit) begin
          w_next      = ST_IDLE;
          w_cause_nxt = CAUSE_BREAK;
          w_skip_set  = 1'b1;
        end
      end
      ST_STEP: begin
        w_next = w_halt_op ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (r_drain_cnt <= NB_DRAIN'(1)) begin
          w_next      = ST_DONE;
          w_cause_nxt = CAUSE_HALT_OP;
        end
      end
      ST_DONE: begin
        if (w_accept && (bus.cmd_i == CMD_CLEAR)) begin
          w_next  = ST_IDLE;
          w_clear = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_clear) w_cause_nxt = CAUSE_NONE;
  end

  assign w_en_nxt = (w_next == ST_RUN) || (w_next == ST_STEP) || (w_next == ST_DRAIN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cause     <= CAUSE_NONE;
      r_en        <= 1'b0;
      r_done      <= 1'b0;
      r_halted    <= 1'b0;
      r_drain_cnt <= '0;
      r_count     <= '0;
    end else begin
      r_state  <= w_next;
      r_cause  <= w_cause_nxt;
      r_en     <= w_en_nxt;
      r_halted <= (w_next == ST_DONE);
      r_done   <= (w_next == ST_DONE) && (r_state != ST_DONE);

      if ((r_state != ST_DRAIN) && (w_next == ST_DRAIN))
        r_drain_cnt <= NB_DRAIN'(DRAIN_LEN);
      else if (r_state == ST_DRAIN)
        r_drain_cnt <= r_drain_cnt - NB_DRAIN'(1);

      // Counter only moves while enabled and CLEAR is only taken while not,
      // so the two never collide.
      if (w_clear)
        r_count <= '0;
      else if (r_en && (r_count != '1))
        r_count <= r_count + NB_CYCLES'(1);
    end
  end

  assign bus.cmd_ready_o = w_ready;
  assign en_pipeline_o   = r_en;
  assign halted_o        = r_halted;
  assign halt_cause_o    = r_cause;
  assign cycle_count_o   = r_count;
  assign done_o          = r_done;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
module tb_pipeline_exec_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int NB_PC    = 7;
  localparam int NB_DATA  = 32;
  localparam int N_STAGES = 5;
  localparam int N_BP     = 2;
  localparam int NB_IDX   = 1;
  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // shared stimulus
  logic              cmd_valid, bp_wr, bp_en;
  logic [2:0]        cmd;
  logic [NB_IDX-1:0] bp_idx;
  logic [NB_PC-1:0]  bp_addr, pc;
  logic [31:0]       instr;

  pipeline_exec_ctrl_if #(.NB_PC(NB_PC), .NB_BP_IDX(NB_IDX)) bus ();
  pipeline_exec_ctrl_if #(.NB_PC(NB_PC), .NB_BP_IDX(NB_IDX)) bus_s ();

  assign bus.cmd_valid_i   = cmd_valid;
  assign bus.cmd_i         = cmd;
  assign bus.bp_wr_i       = bp_wr;
  assign bus.bp_idx_i      = bp_idx;
  assign bus.bp_addr_i     = bp_addr;
  assign bus.bp_en_i       = bp_en;
  assign bus_s.cmd_valid_i = cmd_valid;
  assign bus_s.cmd_i       = cmd;
  assign bus_s.bp_wr_i     = bp_wr;
  assign bus_s.bp_idx_i    = bp_idx;
  assign bus_s.bp_addr_i   = bp_addr;
  assign bus_s.bp_en_i     = bp_en;

  logic        en, halted, done;
  logic [1:0]  cause;
  logic [31:0] count;
  logic        en_s, halted_s, done_s;
  logic [1:0]  cause_s;
  logic [3:0]  count_s;

  pipeline_exec_ctrl #(
    .NB_PC(NB_PC), .NB_DATA(NB_DATA), .N_STAGES(N_STAGES), .NB_CYCLES(32), .N_BP(N_BP)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .pc_fetch_i(pc), .instr_fetch_i(instr),
    .en_pipeline_o(en), .halted_o(halted), .halt_cause_o(cause),
    .cycle_count_o(count), .done_o(done)
  );

  // narrow counter instance, driven identically, used for saturation
  pipeline_exec_ctrl #(
    .NB_PC(NB_PC), .NB_DATA(NB_DATA), .N_STAGES(N_STAGES), .NB_CYCLES(4), .N_BP(N_BP)
  ) dut_s (
    .clock(clock), .reset(reset), .bus(bus_s), .pc_fetch_i(pc), .instr_fetch_i(instr),
    .en_pipeline_o(en_s), .halted_o(halted_s), .halt_cause_o(cause_s),
    .cycle_count_o(count_s), .done_o(done_s)
  );

  int checks = 0;
  int errors = 0;
  logic             halt_on = 1'b0;
  logic [NB_PC-1:0] halt_pc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: fetch PC advances after every enabled cycle, instruction
  // memory returns HALT only at halt_pc when enabled.
  task automatic tick();
    logic en_prev;
    en_prev = en;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    bp_wr     = 1'b0;
    if (en_prev) pc = pc + 1'b1;
    instr = (halt_on && pc == halt_pc) ? HALT_INSTR : 32'h0;
  endtask

  task automatic send(input logic [2:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
  endtask

  task automatic run_to_halt(output int en_cycles, output int dones);
    pc = '0; halt_pc = 7'd9; halt_on = 1'b1; instr = 32'h0;
    send(CMD_RUN);
    en_cycles = 0; dones = 0;
    for (int i = 0; i < 40 && !halted; i++) begin
      if (en) en_cycles++;
      tick();
      if (done) dones++;
    end
    halt_on = 1'b0;
  endtask

  typedef struct {
    logic vld; logic [2:0] cmd; logic halt;
    logic en; logic rdy; logic hlt; logic done; logic [1:0] cause; logic [31:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic v, logic [2:0] c, logic h, logic e, logic r,
                              logic hl, logic d, logic [1:0] ca, int n);
    vec_t t;
    t.vld = v; t.cmd = c; t.halt = h; t.en = e; t.rdy = r;
    t.hlt = hl; t.done = d; t.cause = ca; t.cnt = n;
    return t;
  endfunction

  vec_t tbl[24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ec, dn;
    //            vld cmd        hlt  en rdy hlt dn cause cnt
    tbl[0]  = mk(0, CMD_NOP,   0,   0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, CMD_STEP,  0,   1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, CMD_NOP,   0,   0, 1, 0, 0, 0, 1);
    tbl[3]  = mk(1, CMD_STEP,  0,   1, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, CMD_RUN,   0,   0, 1, 0, 0, 0, 2);  // not ready in STEP
    tbl[5]  = mk(1, CMD_STEP,  0,   1, 0, 0, 0, 0, 2);
    tbl[6]  = mk(0, CMD_NOP,   0,   0, 1, 0, 0, 0, 3);
    tbl[7]  = mk(1, CMD_CLEAR, 0,   0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(1, CMD_RUN,   0,   1, 1, 0, 0, 0, 0);
    tbl[9]  = mk(0, CMD_NOP,   0,   1, 1, 0, 0, 0, 1);
    tbl[10] = mk(0, CMD_NOP,   0,   1, 1, 0, 0, 0, 2);
    tbl[11] = mk(0, CMD_NOP,   0,   1, 1, 0, 0, 0, 3);
    tbl[12] = mk(0, CMD_NOP,   0,   1, 1, 0, 0, 0, 4);
    tbl[13] = mk(1, CMD_PAUSE, 0,   0, 1, 0, 0, 1, 5);
    tbl[14] = mk(1, 3'd7,      0,   0, 1, 0, 0, 1, 5);  // unknown code = NOP
    tbl[15] = mk(1, CMD_RUN,   0,   1, 1, 0, 0, 1, 5);
    tbl[16] = mk(1, CMD_STEP,  0,   1, 1, 0, 0, 1, 6);  // ignored in RUN
    tbl[17] = mk(1, CMD_PAUSE, 1,   1, 0, 0, 0, 1, 7);  // HALT beats PAUSE
    tbl[18] = mk(1, CMD_CLEAR, 0,   1, 0, 0, 0, 1, 8);  // refused in DRAIN
    tbl[19] = mk(0, CMD_NOP,   0,   1, 0, 0, 0, 1, 9);
    tbl[20] = mk(0, CMD_NOP,   0,   1, 0, 0, 0, 1, 10);
    tbl[21] = mk(0, CMD_NOP,   0,   0, 1, 1, 1, 3, 11);
    tbl[22] = mk(1, CMD_RUN,   0,   0, 1, 1, 0, 3, 11); // ignored in DONE
    tbl[23] = mk(1, CMD_CLEAR, 0,   0, 1, 0, 0, 0, 0);

    cmd_valid = 0; cmd = CMD_NOP; bp_wr = 0; bp_idx = '0; bp_addr = '0; bp_en = 0;
    pc = '0; instr = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_en", en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cause", cause, 0);
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", bus.cmd_ready_o, 1);
    chk("rst_small", {en_s, halted_s, cause_s, count_s, done_s}, 0);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      cmd_valid = tbl[i].vld;
      cmd       = tbl[i].cmd;
      if (tbl[i].halt) instr = HALT_INSTR;
      tick();
      chk($sformatf("v%0d_en", i), en, tbl[i].en);
      chk($sformatf("v%0d_ready", i), bus.cmd_ready_o, tbl[i].rdy);
      chk($sformatf("v%0d_halted", i), halted, tbl[i].hlt);
      chk($sformatf("v%0d_done", i), done, tbl[i].done);
      chk($sformatf("v%0d_cause", i), cause, tbl[i].cause);
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
    end

    // RUN until HALT fetched on the 10th enabled cycle, then 4-cycle drain
    run_to_halt(ec, dn);
    chk("halt_en_cycles", ec, 14);
    chk("halt_done_pulses", dn, 1);
    chk("halt_halted", halted, 1);
    chk("halt_cause", cause, 3);
    chk("halt_count", count, 14);
    send(CMD_CLEAR);
    chk("clr_halted", halted, 0);
    chk("clr_count", count, 0);

    // saturation: 20 enabled cycles on a 4-bit counter
    send(CMD_RUN);
    repeat (19) tick();
    send(CMD_PAUSE);
    chk("sat_wide_count", count, 20);
    chk("sat_small_count", count_s, 15);
    chk("sat_en", en, 0);
    send(CMD_CLEAR);
    chk("sat_clr_small", count_s, 0);
    chk("sat_clr_cause", cause, 0);

`ifdef PIPE_CTRL_BREAKPOINT_EN
    bp_wr = 1; bp_idx = 0; bp_addr = 7'h08; bp_en = 1;
    tick();
    pc = '0; instr = 32'h0;
    send(CMD_RUN);
    ec = 0;
    for (int i = 0; i < 30; i++) begin
      if (!en) break;
      ec++;
      tick();
    end
    chk("bp_en_cycles", ec, 9);
    chk("bp_pc_after", pc, 7'h09);
    chk("bp_cause", cause, 2);
    // resume at the breakpoint PC itself: first cycle must not re-halt
    pc = 7'h08;
    send(CMD_RUN);
    repeat (4) tick();
    chk("bp_resume_en", en, 1);
    chk("bp_resume_pc", pc, 7'h0C);
    send(CMD_PAUSE);
    chk("bp_resume_cause", cause, 1);
    // disable slot 0, arm slot 1 at 0x0E
    bp_wr = 1; bp_idx = 0; bp_addr = 7'h08; bp_en = 0;
    tick();
    bp_wr = 1; bp_idx = 1; bp_addr = 7'h0E; bp_en = 1;
    tick();
    pc = 7'h06;
    send(CMD_RUN);
    ec = 0;
    for (int i = 0; i < 30; i++) begin
      if (!en) break;
      ec++;
      tick();
    end
    chk("bp1_en_cycles", ec, 9);
    chk("bp1_cause", cause, 2);
`else
    bp_wr = 1; bp_idx = 0; bp_addr = 7'h02; bp_en = 1;
    tick();
    pc = '0; instr = 32'h0;
    send(CMD_RUN);
    repeat (6) tick();
    chk("nobp_en", en, 1);
    chk("nobp_cause", cause, 0);
    send(CMD_PAUSE);
    chk("nobp_pause_cause", cause, 1);
`endif

    // asynchronous reset in the middle of DRAIN
    pc = '0; halt_pc = 7'd2; halt_on = 1'b1; instr = 32'h0;
    send(CMD_RUN);
    repeat (4) tick();
    chk("drn_en", en, 1);
    chk("drn_ready", bus.cmd_ready_o, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_en", en, 0);
    chk("arst_halted", halted, 0);
    chk("arst_cause", cause, 0);
    chk("arst_count", count, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", bus.cmd_ready_o, 1);
    halt_on = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    run_to_halt(ec, dn);
    chk("rerun_en_cycles", ec, 14);
    chk("rerun_done_pulses", dn, 1);
    chk("rerun_cause", cause, 3);
    chk("rerun_count", count, 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
